// File: rtl/eh2_dec_trigger_csr.sv
// rtl/eh2_dec_trigger_csr.sv - per-thread debug trigger CSRs, LSU hit qualification and dc5 halt/bkpt request
package eh2_trigger_pkg;
  typedef struct packed {
    logic        select;
    logic        match;
    logic        store;
    logic        load;
    logic        execute;
    logic        m;
    logic [31:0] tdata2;
  } eh2_trigger_pkt_t;
endpackage

module eh2_dec_trigger_csr
  import eh2_trigger_pkg::*;
#(
  parameter int NUM_THREADS = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_THREADS-1:0]              dbg_mode,
  input  logic                                csr_wr_en,
  input  logic                                csr_wr_tid,
  input  logic [11:0]                         csr_wr_addr,
  input  logic [31:0]                         csr_wr_data,
  input  logic                                csr_rd_tid,
  input  logic [11:0]                         csr_rd_addr,
  output logic [31:0]                         csr_rd_data,
  output eh2_trigger_pkt_t [NUM_THREADS-1:0][3:0] trigger_pkt_any,
  input  logic                                lsu_valid_dc4,
  input  logic                                lsu_tid_dc4,
  input  logic                                lsu_kill_dc4,
  input  logic [3:0]                          lsu_trigger_match_dc4,
  output logic [3:0]                          trigger_hit_dc5,
  output logic                                trigger_hit_tid_dc5,
  output logic                                trigger_bkpt_dc5,
  output logic                                trigger_halt_dc5
);

  localparam logic [11:0] ADDR_TSELECT = 12'h7A0;
  localparam logic [11:0] ADDR_TDATA1  = 12'h7A1;
  localparam logic [11:0] ADDR_TDATA2  = 12'h7A2;

  logic [NUM_THREADS-1:0][1:0]       tsel;
  logic [NUM_THREADS-1:0][3:0]       dmode, hit, sel, action, chain, match, m, exe, st, ld;
  logic [NUM_THREADS-1:0][3:0][31:0] tdata2;

  logic [1:0] wr_idx, rd_idx;
  logic       wr_locked, wr_tsel, wr_t1, wr_t2, wr_dmode;
  logic       q, c0, c2, halt_nxt, bkpt_nxt;
  logic [3:0] raw, fire, act_vec;

  // A debug-owned trigger (dmode=1) is untouchable from non-debug code.
  always_comb begin
    wr_idx    = tsel[csr_wr_tid];
    wr_locked = dmode[csr_wr_tid][wr_idx] & ~dbg_mode[csr_wr_tid];
    wr_tsel   = csr_wr_en && (csr_wr_addr == ADDR_TSELECT);
    wr_t1     = csr_wr_en && (csr_wr_addr == ADDR_TDATA1) && !wr_locked;
    wr_t2     = csr_wr_en && (csr_wr_addr == ADDR_TDATA2) && !wr_locked;
    wr_dmode  = csr_wr_data[27] & dbg_mode[csr_wr_tid];
  end

  // Chained pairs fire together only when both raw matches are present.
  always_comb begin
    q       = lsu_valid_dc4 & ~lsu_kill_dc4;
    raw     = lsu_trigger_match_dc4;
    c0      = chain[lsu_tid_dc4][0];
    c2      = chain[lsu_tid_dc4][2];
    fire[0] = q & raw[0] & (~c0 | raw[1]);
    fire[1] = q & raw[1] & (~c0 | raw[0]);
    fire[2] = q & raw[2] & (~c2 | raw[3]);
    fire[3] = q & raw[3] & (~c2 | raw[2]);
    act_vec  = action[lsu_tid_dc4];
    halt_nxt = |(fire & act_vec);
    bkpt_nxt = |(fire & ~act_vec) & ~halt_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tsel   <= '0;
      dmode  <= '0;
      hit    <= '0;
      sel    <= '0;
      action <= '0;
      chain  <= '0;
      match  <= '0;
      m      <= '0;
      exe    <= '0;
      st     <= '0;
      ld     <= '0;
      tdata2 <= '0;
      trigger_hit_dc5     <= '0;
      trigger_hit_tid_dc5 <= 1'b0;
      trigger_bkpt_dc5    <= 1'b0;
      trigger_halt_dc5    <= 1'b0;
    end else begin
      if (wr_tsel && (csr_wr_data[31:2] == 30'd0))
        tsel[csr_wr_tid] <= csr_wr_data[1:0];
      for (int t = 0; t < NUM_THREADS; t++) begin
        for (int i = 0; i < 4; i++) begin
          if (wr_t1 && (csr_wr_tid == 1'(t)) && (wr_idx == 2'(i))) begin
            dmode[t][i]  <= wr_dmode;
            hit[t][i]    <= csr_wr_data[20];
            sel[t][i]    <= csr_wr_data[19];
            action[t][i] <= csr_wr_data[12] & wr_dmode;
            chain[t][i]  <= csr_wr_data[11] & ((i == 0) || (i == 2));
            match[t][i]  <= csr_wr_data[7];
            m[t][i]      <= csr_wr_data[6];
            exe[t][i]    <= csr_wr_data[2];
            st[t][i]     <= csr_wr_data[1];
            ld[t][i]     <= csr_wr_data[0];
          end else if (fire[i] && (lsu_tid_dc4 == 1'(t))) begin
            hit[t][i] <= 1'b1;
          end
          if (wr_t2 && (csr_wr_tid == 1'(t)) && (wr_idx == 2'(i)))
            tdata2[t][i] <= csr_wr_data;
        end
      end
      trigger_hit_dc5     <= fire;
      trigger_hit_tid_dc5 <= lsu_tid_dc4;
      trigger_bkpt_dc5    <= bkpt_nxt;
      trigger_halt_dc5    <= halt_nxt;
    end
  end

  always_comb begin
    csr_rd_data = 32'd0;
    rd_idx      = tsel[csr_rd_tid];
    case (csr_rd_addr)
      ADDR_TSELECT: csr_rd_data = {30'd0, rd_idx};
      ADDR_TDATA1: csr_rd_data = {4'h2, dmode[csr_rd_tid][rd_idx], 6'd31,
                                  hit[csr_rd_tid][rd_idx], sel[csr_rd_tid][rd_idx], 6'd0,
                                  action[csr_rd_tid][rd_idx], chain[csr_rd_tid][rd_idx], 3'd0,
                                  match[csr_rd_tid][rd_idx], m[csr_rd_tid][rd_idx], 3'd0,
                                  exe[csr_rd_tid][rd_idx], st[csr_rd_tid][rd_idx],
                                  ld[csr_rd_tid][rd_idx]};
      ADDR_TDATA2: csr_rd_data = tdata2[csr_rd_tid][rd_idx];
      default: csr_rd_data = 32'd0;
    endcase
  end

  // Triggers go silent while their thread is in debug mode.
  always_comb begin
    for (int t = 0; t < NUM_THREADS; t++) begin
      for (int i = 0; i < 4; i++) begin
        trigger_pkt_any[t][i].select  = sel[t][i];
        trigger_pkt_any[t][i].match   = match[t][i];
        trigger_pkt_any[t][i].store   = st[t][i];
        trigger_pkt_any[t][i].load    = ld[t][i];
        trigger_pkt_any[t][i].execute = exe[t][i];
        trigger_pkt_any[t][i].m       = m[t][i] & ~dbg_mode[t];
        trigger_pkt_any[t][i].tdata2  = tdata2[t][i];
      end
    end
  end

endmodule

// File: tb/tb_eh2_dec_trigger_csr.sv
// tb/tb_eh2_dec_trigger_csr.sv - directed self-checking bench for eh2_dec_trigger_csr
module tb_eh2_dec_trigger_csr;
  import eh2_trigger_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  dbg_mode;
  logic        csr_wr_en, csr_wr_tid, csr_rd_tid;
  logic [11:0] csr_wr_addr, csr_rd_addr;
  logic [31:0] csr_wr_data, csr_rd_data;
  eh2_trigger_pkt_t [1:0][3:0] trigger_pkt_any;
  logic        lsu_valid_dc4, lsu_tid_dc4, lsu_kill_dc4;
  logic [3:0]  lsu_trigger_match_dc4, trigger_hit_dc5;
  logic        trigger_hit_tid_dc5, trigger_bkpt_dc5, trigger_halt_dc5;

  int n_checks = 0;
  int n_pass   = 0;

  eh2_dec_trigger_csr #(.NUM_THREADS(2)) dut (
    .clk(clk), .rst(rst), .dbg_mode(dbg_mode),
    .csr_wr_en(csr_wr_en), .csr_wr_tid(csr_wr_tid), .csr_wr_addr(csr_wr_addr),
    .csr_wr_data(csr_wr_data), .csr_rd_tid(csr_rd_tid), .csr_rd_addr(csr_rd_addr),
    .csr_rd_data(csr_rd_data), .trigger_pkt_any(trigger_pkt_any),
    .lsu_valid_dc4(lsu_valid_dc4), .lsu_tid_dc4(lsu_tid_dc4), .lsu_kill_dc4(lsu_kill_dc4),
    .lsu_trigger_match_dc4(lsu_trigger_match_dc4), .trigger_hit_dc5(trigger_hit_dc5),
    .trigger_hit_tid_dc5(trigger_hit_tid_dc5), .trigger_bkpt_dc5(trigger_bkpt_dc5),
    .trigger_halt_dc5(trigger_halt_dc5)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic tid, input logic [11:0] addr, input logic [31:0] data);
    csr_wr_en = 1'b1; csr_wr_tid = tid; csr_wr_addr = addr; csr_wr_data = data;
    tick();
    csr_wr_en = 1'b0;
  endtask

  task automatic rd(input string tag, input logic tid, input logic [11:0] addr, input logic [31:0] exp);
    csr_rd_tid = tid; csr_rd_addr = addr;
    #1;
    check(tag, csr_rd_data, exp);
  endtask

  task automatic lsu(input logic tid, input logic [3:0] mt, input logic kill);
    lsu_valid_dc4 = 1'b1; lsu_tid_dc4 = tid; lsu_trigger_match_dc4 = mt; lsu_kill_dc4 = kill;
    tick();
    lsu_valid_dc4 = 1'b0; lsu_trigger_match_dc4 = 4'd0; lsu_kill_dc4 = 1'b0;
  endtask

  // {hit[3:0], tid, bkpt, halt}
  function automatic logic [31:0] dc5();
    return {25'd0, trigger_hit_dc5, trigger_hit_tid_dc5, trigger_bkpt_dc5, trigger_halt_dc5};
  endfunction

  initial begin
    rst = 1'b1; dbg_mode = 2'b00;
    csr_wr_en = 1'b0; csr_wr_tid = 1'b0; csr_wr_addr = 12'd0; csr_wr_data = 32'd0;
    csr_rd_tid = 1'b0; csr_rd_addr = 12'd0;
    lsu_valid_dc4 = 1'b0; lsu_tid_dc4 = 1'b0; lsu_kill_dc4 = 1'b0; lsu_trigger_match_dc4 = 4'd0;
    tick(); tick();
    rst = 1'b0;

    rd("rst_tdata1", 1'b0, 12'h7A1, 32'h23E00000);
    rd("rst_tselect", 1'b0, 12'h7A0, 32'd0);
    check("rst_dc5", dc5(), 32'd0);
    check("rst_pkt", {31'd0, trigger_pkt_any == '0}, 32'd1);
    rd("unmapped", 1'b0, 12'h123, 32'd0);

    // Thread 1, trigger 2: m + store, plain breakpoint
    wr(1'b1, 12'h7A0, 32'd2);
    wr(1'b1, 12'h7A1, 32'h00000042);
    rd("t1_tsel", 1'b1, 12'h7A0, 32'd2);
    rd("t1_tdata1", 1'b1, 12'h7A1, 32'h23E00042);
    check("t1_pkt", {30'd0, trigger_pkt_any[1][2].m, trigger_pkt_any[1][2].store}, 32'd3);
    lsu(1'b1, 4'b0100, 1'b0);
    check("t1_hit_dc5", dc5(), {25'd0, 4'b0100, 1'b1, 1'b1, 1'b0});
    rd("t1_hit_sticky", 1'b1, 12'h7A1, 32'h23F00042);
    tick();
    check("t1_pulse_1cyc", dc5(), {25'd0, 4'b0000, 1'b1, 1'b0, 1'b0});

    // Thread 0 chain on trigger 0
    wr(1'b0, 12'h7A1, 32'h00000842);
    rd("chain0_rd", 1'b0, 12'h7A1, 32'h23E00842);
    lsu(1'b0, 4'b0001, 1'b0);
    check("chain_half", {28'd0, trigger_hit_dc5}, 32'd0);
    lsu(1'b0, 4'b0011, 1'b0);
    check("chain_both", dc5(), {25'd0, 4'b0011, 1'b0, 1'b1, 1'b0});
    rd("chain_hit0", 1'b0, 12'h7A1, 32'h23F00842);
    wr(1'b0, 12'h7A0, 32'd1);
    wr(1'b0, 12'h7A1, 32'h00000842);
    rd("chain1_cleared", 1'b0, 12'h7A1, 32'h23E00042);

    // Debug-mode owned trigger with action=1 (thread 1, trigger 2)
    dbg_mode = 2'b10;
    wr(1'b1, 12'h7A1, 32'h08001042);
    rd("dmode_rd", 1'b1, 12'h7A1, 32'h2BE01042);
    check("pkt_m_dbg", {31'd0, trigger_pkt_any[1][2].m}, 32'd0);
    dbg_mode = 2'b00;
    #1;
    check("pkt_m_nodbg", {31'd0, trigger_pkt_any[1][2].m}, 32'd1);
    lsu(1'b1, 4'b0100, 1'b0);
    check("halt", dc5(), {25'd0, 4'b0100, 1'b1, 1'b0, 1'b1});
    wr(1'b1, 12'h7A1, 32'h00000042);
    rd("locked_t1", 1'b1, 12'h7A1, 32'h2BF01042);
    wr(1'b1, 12'h7A2, 32'h00001234);
    rd("locked_t2", 1'b1, 12'h7A2, 32'd0);
    wr(1'b0, 12'h7A0, 32'd3);
    wr(1'b0, 12'h7A1, 32'h08001042);
    rd("dmode_forced0", 1'b0, 12'h7A1, 32'h23E00042);

    // Kill suppresses hits
    lsu(1'b0, 4'hF, 1'b1);
    check("kill_dc5", dc5(), 32'd0);
    rd("kill_t3", 1'b0, 12'h7A1, 32'h23E00042);
    wr(1'b0, 12'h7A0, 32'd0);
    rd("kill_t0", 1'b0, 12'h7A1, 32'h23F00842);

    // Write and hit on same trigger in same cycle: write wins
    csr_wr_en = 1'b1; csr_wr_tid = 1'b0; csr_wr_addr = 12'h7A1; csr_wr_data = 32'h00000842;
    lsu(1'b0, 4'b0011, 1'b0);
    csr_wr_en = 1'b0;
    rd("wr_beats_hit", 1'b0, 12'h7A1, 32'h23E00842);
    check("wr_hit_dc5", {28'd0, trigger_hit_dc5}, 32'b0011);

    // Out-of-range tselect ignored; tdata2 path
    wr(1'b0, 12'h7A0, 32'd1);
    wr(1'b0, 12'h7A0, 32'd5);
    rd("tsel_5_ignored", 1'b0, 12'h7A0, 32'd1);
    wr(1'b0, 12'h7A2, 32'hDEADBEEF);
    rd("tdata2_rd", 1'b0, 12'h7A2, 32'hDEADBEEF);
    check("tdata2_pkt", trigger_pkt_any[0][1].tdata2, 32'hDEADBEEF);

    // Reset beats a concurrent write
    rst = 1'b1;
    wr(1'b1, 12'h7A0, 32'd3);
    rst = 1'b0;
    rd("rst2_tsel", 1'b1, 12'h7A0, 32'd0);
    rd("rst2_tdata1", 1'b1, 12'h7A1, 32'h23E00000);
    check("rst2_pkt", {31'd0, trigger_pkt_any == '0}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/eh2_dec_trigger_csr.md
# eh2_dec_trigger_csr

Per-thread debug-trigger CSR file and hit handler. It owns tselect/tdata1/tdata2 for 4 triggers per thread, drives the `trigger_pkt_any` packets consumed by the LSU trigger matcher, and takes back the raw per-trigger LSU match vector. It applies chaining, debug-mode and kill qualification, records sticky hit bits, and issues a registered breakpoint/debug-halt request to the decode/TLU pipeline.

## Interface
- `NUM_THREADS`, default 2: hardware threads, each with 4 triggers.
- `clk`  in  1  sole clock.
- `rst`  in  1  reset, synchronous and active-high.
- `dbg_mode`  in  NUM_THREADS  thread is in debug mode.
- `csr_wr_en`  in  1  CSR write strobe.
- `csr_wr_tid`  in  1  write thread.
- `csr_wr_addr`  in  12  0x7A0 tselect, 0x7A1 tdata1, 0x7A2 tdata2; other addresses ignored.
- `csr_wr_data`  in  32  write data.
- `csr_rd_tid`  in  1  read thread.
- `csr_rd_addr`  in  12  read address.
- `csr_rd_data`  out  32  combinational read data; 0 for unmapped addresses.
- `trigger_pkt_any`  out  eh2_trigger_pkt_t [NUM_THREADS-1:0][3:0]  select, match, store, load, execute, m, tdata2 per trigger.
- `lsu_valid_dc4`  in  1  LSU dc4 op valid (non-DMA).
- `lsu_tid_dc4`  in  1  dc4 thread.
- `lsu_kill_dc4`  in  1  dc4 op flushed.
- `lsu_trigger_match_dc4`  in  4  raw per-trigger match from the LSU.
- `trigger_hit_dc5`  out  4  qualified hits, registered.
- `trigger_hit_tid_dc5`  out  1  thread of hit.
- `trigger_bkpt_dc5`  out  1  breakpoint exception request (action=0).
- `trigger_halt_dc5`  out  1  debug-halt request (action=1).

## Operation
- tdata1 layout: [31:28] type, RO 4'h2. [27] dmode. [26:21] maskmax, RO 6'd31. [20] hit. [19] select. [12] action. [11] chain. [7] match (0 equal, 1 NAPOT). [6] m. [2] execute. [1] store. [0] load. All other bits read 0.
- tselect: a write with data ≤ 3 sets the thread's index. A write with data > 3 is ignored. Reads return 0..3.
- tdata1/tdata2 accesses target trigger `tselect[csr_wr_tid]`.
- Write protection:
  - If the stored dmode=1 and `dbg_mode[tid]`=0, writes to tdata1 and tdata2 are ignored.
  - Outside debug mode, a written dmode is forced to 0.
  - action is stored as written only when the resulting dmode=1; otherwise it is stored as 0.
- Chain is legal only on triggers 0 and 2. The chain bit on triggers 1 and 3 is stored as 0.
- Packet drive:
  - `trigger_pkt_any[t][i]` fields mirror the registers.
  - `.m` = stored m & ~`dbg_mode[t]`, so triggers are silent in debug mode.
- Qualification (dc4), with q = `lsu_valid_dc4` & ~`lsu_kill_dc4` and raw = `lsu_trigger_match_dc4`:
  - Pair (0,1), when chain0=1: fire0 = fire1 = raw0 & raw1 & q.
  - Pair (0,1), when chain0=0: each fires on its own raw & q.
  - Pair (2,3) behaves the same, using chain2.
- Hit update (dc4 → dc5 edge):
  - For each fired trigger of `lsu_tid_dc4`, set hit.
  - `trigger_hit_dc5` is loaded with the fire vector.
  - `trigger_hit_tid_dc5` is loaded with `lsu_tid_dc4`.
  - `trigger_halt_dc5` = OR of fired triggers with action=1.
  - `trigger_bkpt_dc5` = OR of fired triggers with action=0, gated by ~halt (halt has priority).
- Hit bit is sticky until software writes tdata1.
- A CSR tdata1 write and a hardware hit to the same trigger in the same cycle: the write wins and its hit value is stored.
- Hits on different triggers or threads in the same cycle as a write are both applied.

## Timing
- Reset (`rst`=1 at a clk edge):
  - tselect = 0.
  - tdata1 writable fields = 0, so reads return 0x23E00000.
  - tdata2 = 0.
  - All dc5 outputs = 0.
  - `trigger_pkt_any` is all zero.
- Reset has priority over a concurrent write or hit.
- CSR write latency: register visible on `csr_rd_data` and `trigger_pkt_any` in the cycle after `csr_wr_en`.
- No write-to-read bypass.
- Match-to-request latency: 1 cycle. A dc4 match at edge N produces a dc5 pulse during cycle N+1, lasting exactly 1 cycle per qualifying op.
- A `dbg_mode` change affects `.m` combinationally in the same cycle.
- No stalls or backpressure: every dc4 cycle is accepted.

## Test plan
- Reset, then read 0x7A1 for tid 0 → 0x23E00000. Read 0x7A0 → 0. Check dc5 outputs = 0.
- Write tselect=2 and tdata1=0x00000042 (m, store) for tid 1. Then `lsu_valid_dc4`=1, tid=1, match=4'b0100 → next cycle `trigger_hit_dc5`=4'b0100, tid=1, bkpt=1. tdata1 read shows bit 20 set.
- Set chain0=1 on trigger 0. Drive match=4'b0001 → no hit. Drive match=4'b0011 → `trigger_hit_dc5`=4'b0011.
- In debug mode, write tdata1=0x08001042 (dmode, action). Exit debug. A match on that trigger → halt=1, bkpt=0. A non-debug write to the same trigger is ignored.
- `lsu_kill_dc4`=1 with match=4'hF → no hit, hit bits unchanged. Then a tdata1 write with hit=0 in the same cycle as a match on the same trigger → hit reads 0.
- Write tselect=5 → tselect read unchanged.
